// File: rtl/button_matrix_scanner.sv
// button_matrix_scanner: column-strobed N x N switch matrix reader.
// Drives one column at a time, samples the rows on the last settle clock of
// that column, assembles an N*N bitmap (bit N*row+col) and accepts a new
// bitmap only after DEBOUNCE_SCANS consecutive identical frames.
module button_matrix_scanner #(
  parameter int N              = 5,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         rows_in,
  output logic [N-1:0]         cols_out,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       buttons,
  output logic                 scan_done,
  output logic                 changed
);

  localparam int XW = $clog2(N) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [N*N-1:0]   raw_q, raw_d;
  logic [N*N-1:0]   cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N*N-1:0]   btn_q, btn_d;
  logic [N-1:0]     cols_q, cols_d;
  logic             done_q, done_d;
  logic             chg_q, chg_d;

  // Next-state, frame assembly and debounce decision.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    settle_d = settle_q;
    raw_d    = raw_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    btn_d    = btn_q;
    done_d   = 1'b0;
    chg_d    = 1'b0;

    case (state_q)
      IDLE: begin
        x_d      = '0;
        settle_d = '0;
        if (ena) begin
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end

      DRIVE: begin
        if (!ena) begin
          // Abandon the partial frame; candidate and buttons survive.
          state_d  = IDLE;
          x_d      = '0;
          settle_d = '0;
          cnt_d    = '0;
        end else if (settle_q == SETTLE_LAST) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              if (x_q == XW'(c)) begin
                raw_d[N*r+c] = rows_in[r];
              end else begin
                raw_d[N*r+c] = raw_q[N*r+c];
              end
            end
          end
          settle_d = '0;
          if (x_q == X_LAST) begin
            state_d = EVAL;
            x_d     = '0;
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      EVAL: begin
        state_d  = ena ? DRIVE : IDLE;
        x_d      = '0;
        settle_d = '0;
        done_d   = 1'b1;
        if (raw_q == cand_q) begin
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cand_d = raw_q;
          cnt_d  = CW'(1);
        end
        if ((cnt_d == CNT_MAX) && (raw_q != btn_q)) begin
          btn_d = raw_q;
          chg_d = 1'b1;
        end else begin
          btn_d = btn_q;
          chg_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        x_d      = '0;
        settle_d = '0;
      end
    endcase

    // Column drive follows the upcoming state so it is registered with x.
    for (int c = 0; c < N; c++) begin
      cols_d[c] = (state_d == DRIVE) && (x_d == XW'(c));
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      settle_q <= '0;
      raw_q    <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      btn_q    <= '0;
      cols_q   <= '0;
      done_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      settle_q <= settle_d;
      raw_q    <= raw_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_d;
      cols_q   <= cols_d;
      done_q   <= done_d;
      chg_q    <= chg_d;
    end
  end

  assign cols_out  = cols_q;
  assign x         = x_q;
  assign buttons   = btn_q;
  assign scan_done = done_q;
  assign changed   = chg_q;

endmodule
